// File: rtl/tru8bit_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and sizing helpers.
package tru8bit_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/tru8bit_serial_fs.sv
// Gate-level full subtractor cell: d = a - b - bi, bo = borrow out.
module fs (
    output logic bo,
    output logic d,
    input  logic a,
    input  logic b,
    input  logic bi
);

    logic a_xor_b;
    logic borrow_ab;
    logic borrow_in;

    assign a_xor_b   = a ^ b;
    assign d         = a_xor_b ^ bi;
    assign borrow_ab = ~a & b;
    assign borrow_in = ~a_xor_b & bi;
    assign bo        = borrow_ab | borrow_in;

endmodule

// File: rtl/tru8bit_serial.sv
// Bit-serial subtractor: a - b processed LSB first through one fs cell,
// with a start/busy/done handshake and a WIDTH+1 bit {borrow, difference} result.
module tru8bit_serial
    import tru8bit_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   d,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic diff;
    logic bout;

    fs u_fs (
        .bo (bout),
        .d  (diff),
        .a  (a_q[0]),
        .b  (b_q[0]),
        .bi (borrow_q)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                // Difference bits enter at the MSB so bit 0 ends up at the LSB after WIDTH shifts.
                res_d    = {diff, res_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                borrow_d = bout;
                if (cnt_q == LAST_BIT) begin
                    d_d     = {bout, diff, res_q[WIDTH-1:1]};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                d_d     = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            d_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign d    = d_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
